// File: rtl/sim_ram_arb_pkg.sv
// Shared types and helpers for the simulation RAM arbiter and its round-robin grant logic.
package sim_ram_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef logic [2:0] req_id_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } ram_op_e;

    // Round-robin successor of id among n requesters.
    function automatic req_id_t next_prio(input req_id_t id, input int n);
        if (int'(id) + 1 >= n)
            return '0;
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin grant: first set request at or after prio, wrapping modulo N.
module rr_grant
    import sim_ram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  req_id_t      prio,
    output logic [N-1:0] grant,
    output req_id_t      win_id
);

    logic found;

    always_comb begin
        grant  = '0;
        win_id = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(prio) + k;
            if (j >= N)
                j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                win_id   = req_id_t'(j);
            end
        end
    end

endmodule

// File: rtl/sim_ram_arbiter.sv
// Round-robin sharing of one simulation RAM between NUM_REQ requesters, one op per cycle.
// Optional per-requester statistics counters enabled by SIM_RAM_ARB_STATS_EN.
module sim_ram_arbiter
    import sim_ram_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 2,
    parameter int  DATA_SIZE  = 4,
    parameter int  ADDR_WIDTH = 8,
    localparam int DATA_WIDTH = 8 * DATA_SIZE,
    localparam int ADDR_START = $clog2(DATA_SIZE),
    localparam int WORD_AW    = ADDR_WIDTH - ADDR_START
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ-1:0]                  req_we,
    input  logic [NUM_REQ-1:0][WORD_AW-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic                                ram_rd_en,
    output logic [WORD_AW-1:0]                  ram_rd_addr,
    output logic                                ram_wr_en,
    output logic [WORD_AW-1:0]                  ram_wr_addr,
    output logic [DATA_WIDTH-1:0]               ram_wr_data,
    input  logic [DATA_WIDTH-1:0]               ram_rd_data,
    input  logic                                ram_rd_valid
);

    req_id_t              prio_q;
    req_id_t              rsp_id_q;
    logic                 inflight_q;
    req_id_t              win_id;
    logic [NUM_REQ-1:0]   grant;
    logic                 fire;
    ram_op_e              op;
    logic                 sel_we;
    logic [WORD_AW-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_grant #(.N(NUM_REQ)) u_grant (
        .req    (req_valid),
        .prio   (prio_q),
        .grant  (grant),
        .win_id (win_id)
    );

    // Grant is one-hot, so an OR of masked fields selects the winner's request.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we    = sel_we    | (grant[i] & req_we[i]);
            sel_addr  = sel_addr  | ({WORD_AW{grant[i]}} & req_addr[i]);
            sel_wdata = sel_wdata | ({DATA_WIDTH{grant[i]}} & req_wdata[i]);
        end
        fire        = |grant;
        op          = sel_we ? OP_WR : OP_RD;
        req_ready   = grant;
        ram_rd_en   = fire && (op == OP_RD);
        ram_wr_en   = fire && (op == OP_WR);
        ram_rd_addr = sel_addr;
        ram_wr_addr = sel_addr;
        ram_wr_data = sel_wdata;
        rsp_data    = ram_rd_data;
        for (int i = 0; i < NUM_REQ; i++)
            rsp_valid[i] = inflight_q && (rsp_id_q == req_id_t'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= '0;
            inflight_q <= 1'b0;
            rsp_id_q   <= '0;
        end else begin
            if (fire)
                prio_q <= next_prio(win_id, NUM_REQ);
            inflight_q <= ram_rd_en;
            if (ram_rd_en)
                rsp_id_q <= win_id;
        end
    end

    // Response timing comes from inflight_q; the RAM's own valid only cross-checks it.
    assert property (@(posedge clk) disable iff (rst) inflight_q |-> ram_rd_valid);
    assert property (@(posedge clk) disable iff (rst) !(ram_rd_en && ram_wr_en));

`ifdef SIM_RAM_ARB_STATS_EN
    logic [31:0] grant_cnt [NUM_REQ];
    logic [31:0] wait_cnt  [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && grant[i] && grant_cnt[i] != '1)
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                if (req_valid[i] && !grant[i] && wait_cnt[i] != '1)
                    wait_cnt[i] <= wait_cnt[i] + 32'd1;
            end
        end
    end

    function automatic void dump_stats();
        for (int i = 0; i < NUM_REQ; i++)
            $display("sim_ram_arbiter req %0d: grants=%0d waits=%0d", i, grant_cnt[i], wait_cnt[i]);
    endfunction
`endif

endmodule

// File: tb/tb_sim_ram_arbiter.sv
// Directed bench for sim_ram_arbiter with a queue-based read-response scoreboard.
module tb_sim_ram_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][5:0]   req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_data;
    logic              ram_rd_en;
    logic [5:0]        ram_rd_addr;
    logic              ram_wr_en;
    logic [5:0]        ram_wr_addr;
    logic [31:0]       ram_wr_data;
    logic [31:0]       ram_rd_data;
    logic              ram_rd_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    logic exp_rsp_next = 1'b0;
    logic [31:0] mem [64];

    always #5 clk = ~clk;

    sim_ram_arbiter #(.NUM_REQ(2), .DATA_SIZE(4), .ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_wr_en    (ram_wr_en),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_valid (ram_rd_valid)
    );

    // RAM model: 1-cycle read latency, write visible from the next edge.
    always @(posedge clk) begin
        if (ram_wr_en)
            mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en)
            ram_rd_data <= mem[ram_rd_addr];
        ram_rd_valid <= ram_rd_en;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        #1;
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        #1;
        chk("rd_wr_exclusive", {63'd0, ram_rd_en & ram_wr_en}, 64'd0);
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 32'd0, 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: pops an expected response whenever the DUT presents one,
    // and requires a response exactly one cycle after every read handshake.
    initial begin
        rsp_t e;
        int   id_act;
        forever begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || exp_rsp_next) begin
                if (rsp_valid == 2'b00) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_latency: got rsp_valid=%b expected a response", rsp_valid);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=%b expected none", rsp_valid);
                end else begin
                    e = exp_q.pop_front();
                    id_act = (rsp_valid == 2'b01) ? 0 : (rsp_valid == 2'b10) ? 1 : 99;
                    chk("rsp_id", 64'(id_act), 64'(e.id));
                    chk("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
                end
            end
            #4;
            exp_rsp_next = !rst && |(req_valid & req_ready & ~req_we);
        end
    end

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_we       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < 64; i++)
            mem[i] = 32'h0;
        mem[6'h10] = 32'h11111111;
        mem[6'h20] = 32'h22222222;
        mem[6'h12] = 32'hAAAA0012;

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("reset_ready", {62'd0, req_ready}, 64'd0);
        #1 rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            idle();
            chk("idle_ready", {62'd0, req_ready}, 64'd0);
            chk("idle_rsp", {62'd0, rsp_valid}, 64'd0);
            chk("idle_en", {62'd0, ram_rd_en, ram_wr_en}, 64'd0);
        end

        // Write then read back the same word
        drive(2'b01, 2'b01, 6'h05, 6'h00, 32'hDEADBEEF, 32'h0);
        chk("wr_ready", {62'd0, req_ready}, 64'h1);
        chk("wr_en", {62'd0, ram_rd_en, ram_wr_en}, 64'h1);
        chk("wr_addr", {58'd0, ram_wr_addr}, 64'h05);
        chk("wr_data", {32'd0, ram_wr_data}, 64'hDEADBEEF);
        drive(2'b01, 2'b00, 6'h05, 6'h00, 32'h0, 32'h0);
        chk("rd_ready", {62'd0, req_ready}, 64'h1);
        chk("rd_en", {62'd0, ram_rd_en, ram_wr_en}, 64'h2);
        chk("rd_addr", {58'd0, ram_rd_addr}, 64'h05);
        exp_q.push_back('{id: 0, data: 32'hDEADBEEF});
        idle();

        // Continuous reads from both requesters alternate from prio 0
        reset_pulse();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 2'b00, 6'h10, 6'h20, 32'h0, 32'h0);
            chk("alt_ready", {62'd0, req_ready}, (c % 2 == 0) ? 64'h1 : 64'h2);
            chk("alt_rd_addr", {58'd0, ram_rd_addr}, (c % 2 == 0) ? 64'h10 : 64'h20);
            if (c % 2 == 0)
                exp_q.push_back('{id: 0, data: 32'h11111111});
            else
                exp_q.push_back('{id: 1, data: 32'h22222222});
        end
        idle();

        // Same-address read/write collision at prio 0: read first, old value
        drive(2'b11, 2'b10, 6'h12, 6'h12, 32'h0, 32'hBBBB0012);
        chk("coll_ready_rd", {62'd0, req_ready}, 64'h1);
        chk("coll_en_rd", {62'd0, ram_rd_en, ram_wr_en}, 64'h2);
        exp_q.push_back('{id: 0, data: 32'hAAAA0012});
        drive(2'b10, 2'b10, 6'h12, 6'h12, 32'h0, 32'hBBBB0012);
        chk("coll_ready_wr", {62'd0, req_ready}, 64'h2);
        chk("coll_en_wr", {62'd0, ram_rd_en, ram_wr_en}, 64'h1);
        chk("coll_wr_data", {32'd0, ram_wr_data}, 64'hBBBB0012);
        drive(2'b01, 2'b00, 6'h12, 6'h00, 32'h0, 32'h0);
        chk("coll_ready_rd2", {62'd0, req_ready}, 64'h1);
        exp_q.push_back('{id: 0, data: 32'hBBBB0012});
        idle();

        // Reset lands on an accepted read: no response, priority back to 0
        drive(2'b10, 2'b00, 6'h00, 6'h20, 32'h0, 32'h0);
        chk("pre_rst_ready", {62'd0, req_ready}, 64'h2);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_rsp", {62'd0, rsp_valid}, 64'd0);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("rst_hold_rsp", {62'd0, rsp_valid}, 64'd0);
        #1 rst = 1'b0;
        drive(2'b11, 2'b00, 6'h10, 6'h20, 32'h0, 32'h0);
        chk("post_rst_ready", {62'd0, req_ready}, 64'h1);
        exp_q.push_back('{id: 0, data: 32'h11111111});
        drive(2'b10, 2'b00, 6'h10, 6'h20, 32'h0, 32'h0);
        chk("post_rst_ready2", {62'd0, req_ready}, 64'h2);
        exp_q.push_back('{id: 1, data: 32'h22222222});
        idle();

`ifdef SIM_RAM_ARB_STATS_EN
        reset_pulse();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 2'b00, 6'h10, 6'h20, 32'h0, 32'h0);
            if (c % 2 == 0)
                exp_q.push_back('{id: 0, data: 32'h11111111});
            else
                exp_q.push_back('{id: 1, data: 32'h22222222});
        end
        idle();
        chk("grant_cnt0", {32'd0, dut.grant_cnt[0]}, 64'd4);
        chk("grant_cnt1", {32'd0, dut.grant_cnt[1]}, 64'd4);
        chk("wait_cnt0", {32'd0, dut.wait_cnt[0]}, 64'd4);
        chk("wait_cnt1", {32'd0, dut.wait_cnt[1]}, 64'd4);
`endif

        repeat (3) idle();
        chk("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sim_ram_arbiter.md
Name: sim_ram_arbiter

Overview:
- Round-robin arbiter that shares one single-port-per-direction simulation RAM instance between NUM_REQ requesters, e.g. instruction fetch and load/store.
- Issues at most one RAM operation per cycle, so a read and a write never hit the same address in the same cycle.
- Routes each 1-cycle-latency read response back to the requester that issued it.
- Sits between core-side memory ports and the RAM model in simulation tops.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- DATA_SIZE, 4, bytes per access (1, 2 or 4); DATA_WIDTH = 8*DATA_SIZE.
- ADDR_WIDTH, 8, byte-address width; word address is [ADDR_WIDTH-1:ADDR_START], ADDR_START = clog2(DATA_SIZE).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle, one-hot or zero.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ x (ADDR_WIDTH-ADDR_START)  word address.
- req_wdata  in  NUM_REQ x DATA_WIDTH  write data.
- rsp_valid  out  NUM_REQ  read data valid, one-hot or zero.
- rsp_data  out  DATA_WIDTH  read data, shared by all requesters.
- ram_rd_en / ram_rd_addr  out  1 / (ADDR_WIDTH-ADDR_START)  RAM read port.
- ram_wr_en / ram_wr_addr / ram_wr_data  out  1 / (ADDR_WIDTH-ADDR_START) / DATA_WIDTH  RAM write port.
- ram_rd_data  in  DATA_WIDTH  RAM read data.
- ram_rd_valid  in  1  RAM read-valid; used for checking only.

Behaviour:
- Reset values: prio_q=0, inflight_q=0, rsp_id_q=0; req_ready=0, rsp_valid=0, ram_rd_en=0, ram_wr_en=0.
- Grant (combinational):
  - Search req_valid starting at index prio_q, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready = one-hot of the winner; all zero if no request.
  - Handshake fires on req_valid[i] && req_ready[i].
- Requester rule: hold valid, we, addr and wdata stable until ready. Valid may not be dropped before acceptance.
- RAM drive, same cycle as the handshake:
  - Read: ram_rd_en=1, ram_rd_addr=winner addr.
  - Write: ram_wr_en=1, ram_wr_addr and ram_wr_data from the winner.
  - ram_rd_en and ram_wr_en are never both 1.
- Priority update on a handshake: prio_q <= (winner+1) mod NUM_REQ. With no handshake, prio_q holds.
- Read response:
  - On a read handshake, inflight_q<=1 and rsp_id_q<=winner; otherwise inflight_q<=0.
  - rsp_valid[rsp_id_q] = inflight_q; rsp_data = ram_rd_data. Latency is exactly 1 cycle after acceptance.
- Writes produce no response. Write data is visible to a read accepted the following cycle or later.
- Throughput: one accepted op per cycle. Back-to-back reads from any mix of requesters yield back-to-back responses with no bubbles.
- Responses have no backpressure; requesters must sink rsp_valid unconditionally.
- NUM_REQ=1: prio_q is constant 0 and the grant is req_valid[0].
- Reset mid-operation: an in-flight read is dropped, rsp_valid stays 0, and priority returns to 0.
- rsp_valid is generated from inflight_q, never from ram_rd_valid. ram_rd_valid is not reset in the RAM model and is X until the first clock edge.
- Simulation assertion: when inflight_q==1, ram_rd_valid must be 1.

Optional Feature:
- Macro SIM_RAM_ARB_STATS_EN.
- When defined:
  - Per-requester 32-bit counters grant_cnt[i] (handshakes) and wait_cnt[i] (cycles with valid && !ready), cleared by rst and saturating at max.
  - Function dump_stats() $displays all counters.
  - Counters are readable hierarchically by the testbench.
- When undefined: no counters and no function; the ports are identical either way.

Decomposition:
- Package sim_ram_arb_pkg holds:
  - MAX_REQ = 8.
  - typedef req_id_t = logic [2:0].
  - enum ram_op_e {OP_RD, OP_WR}.
  - function next_prio(id, n).
- Sub-module rr_grant, purely combinational:
  - Inputs: req vector, prio pointer.
  - Outputs: one-hot grant and winner id.
  - Reused by future bus arbiters.

Test Plan:
- Reset then idle -> all req_ready, rsp_valid, ram_rd_en and ram_wr_en stay 0 for 10 cycles.
- Req0 writes 0xDEADBEEF to word 0x05, then req0 reads 0x05 next cycle -> ram_wr_en for 1 cycle; rsp_valid[0]=1 with rsp_data=0xDEADBEEF exactly 1 cycle after the read handshake.
- Req0 and req1 read continuously (addrs 0x10 and 0x20, preloaded 0x11111111 and 0x22222222) -> grants alternate 0,1,0,1; responses alternate with matching ids and data; no idle cycles.
- Req1 writes 0x12 while req0 reads 0x12 in the same cycle with prio_q=0 -> read granted first and returns the old value; write granted next cycle; ram_rd_en and ram_wr_en never both 1.
- Read accepted, rst asserted before the next edge -> rsp_valid stays 0; after reset, a simultaneous req0/req1 request grants req0.
- With SIM_RAM_ARB_STATS_EN, 8 cycles of both requesters valid -> grant_cnt={4,4}, wait_cnt={4,4}.
